// File: rtl/sar_adc_sequencer.sv
// SAR ADC sequencer: round-robin arbitration over NCH requesters,
// sample phase, then bitwise successive approximation on a shared core.
module sar_adc_sequencer #(
  parameter int NBITS         = 8,
  parameter int NCH           = 4,
  parameter int CHW           = 2,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   ack,
  output logic             busy,
  output logic [CHW-1:0]   ch_sel,
  output logic             sample_en,
  output logic [NBITS-1:0] dac_code,
  output logic             cmp_latch,
  input  logic             cmp_in,
  output logic             result_valid,
  output logic [NBITS-1:0] result_data,
  output logic [CHW-1:0]   result_ch
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ?
                        SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [CHW-1:0]   rr;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_i;
  logic [NBITS-1:0] acc;
  logic             rest;

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [CHW-1:0]   gnt;
  logic             gnt_v;
  int               s;

  // Rotate req so bit 0 is the channel just after rr; lowest set bit wins.
  always_comb begin
    dbl   = {req, req};
    rot   = NCH'(dbl >> (int'(rr) + 1));
    gnt   = '0;
    gnt_v = 1'b0;
    s     = 0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_v = 1'b1;
        s     = int'(rr) + 1 + j;
        if (s >= NCH) s = s - NCH;
        gnt   = CHW'(s);
      end
    end
  end

  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] next_mask;
  logic [NBITS-1:0] acc_n;

  always_comb begin
    bit_mask  = NBITS'(1) << bit_i;
    next_mask = bit_mask >> 1;
    acc_n     = cmp_in ? (acc | bit_mask) : (acc & ~bit_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr           <= CHW'(NCH - 1);
      cnt          <= '0;
      bit_i        <= '0;
      acc          <= '0;
      rest         <= 1'b0;
      busy         <= 1'b0;
      ch_sel       <= '0;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      cmp_latch    <= 1'b0;
      ack          <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
    end else begin
      ack          <= '0;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // One idle cycle after DONE before arbitrating again.
          if (rest) begin
            rest <= 1'b0;
          end else if (en && gnt_v) begin
            ch_sel    <= gnt;
            rr        <= gnt;
            busy      <= 1'b1;
            sample_en <= 1'b1;
            cnt       <= CW'(SAMPLE_CYCLES - 1);
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            sample_en <= 1'b0;
            acc       <= '0;
            bit_i     <= BW'(NBITS - 1);
            dac_code  <= NBITS'(1) << (NBITS - 1);
            cnt       <= CW'(SETTLE_CYCLES - 1);
            state     <= SETTLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            cmp_latch <= 1'b1;
            state     <= COMPARE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        COMPARE: begin
          cmp_latch <= 1'b0;
          acc       <= acc_n;
          if (bit_i == '0) begin
            result_valid <= 1'b1;
            result_data  <= acc_n;
            result_ch    <= ch_sel;
            ack          <= NCH'(1) << ch_sel;
            dac_code     <= '0;
            state        <= DONE;
          end else begin
            bit_i    <= bit_i - BW'(1);
            dac_code <= acc_n | next_mask;
            cnt      <= CW'(SETTLE_CYCLES - 1);
            state    <= SETTLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          rest  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Scoreboard bench for sar_adc_sequencer: directed requests against
// a per-channel comparator model with hand-picked codes.
module tb_sar_adc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] ch_sel;
  logic       sample_en;
  logic [7:0] dac_code;
  logic       cmp_latch;
  logic       cmp_in;
  logic       result_valid;
  logic [7:0] result_data;
  logic [1:0] result_ch;

  sar_adc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req          (req),
    .ack          (ack),
    .busy         (busy),
    .ch_sel       (ch_sel),
    .sample_en    (sample_en),
    .dac_code     (dac_code),
    .cmp_latch    (cmp_latch),
    .cmp_in       (cmp_in),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_ch    (result_ch)
  );

  always #5 clk = ~clk;

  logic [7:0] code [4];
  assign cmp_in = (code[ch_sel] >= dac_code);

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] trials[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d",
               nm, act, want, cyc);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (cmp_latch) trials.push_back(dac_code);
    if (sample_en || cmp_latch)
      chk("strobe_excl", 32'(sample_en && cmp_latch), 0);
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got ch %0d data %0h expected none",
                 result_ch, result_data);
      end else begin
        e = sb.pop_front();
        chk("res_data", 32'(result_data), 32'(e.d));
        chk("res_ch",   32'(result_ch),   32'(e.ch));
        chk("ack",      32'(ack),         32'(4'b0001 << e.ch));
        chk("latency",  32'(cyc),         32'(e.cyc));
      end
    end else if (ack != '0) begin
      chk("stray_ack", 32'(ack), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] ch,
                      input int c);
    exp_t x;
    x.d   = d;
    x.ch  = ch;
    x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
    tick(3);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_busy",   32'(busy), 0);
    chk("rst_ack",    32'(ack), 0);
    chk("rst_valid",  32'(result_valid), 0);
    chk("rst_sample", 32'(sample_en), 0);
    chk("rst_latch",  32'(cmp_latch), 0);
    chk("rst_dac",    32'(dac_code), 0);
    chk("rst_data",   32'(result_data), 0);
    chk("rst_ch",     32'({ch_sel, result_ch}), 0);
  endtask

  int p;
  logic [7:0] t;

  initial begin
    for (int i = 0; i < 4; i++) code[i] = '0;
    tick(1);

    // single conversion, code A5 on ch2
    do_reset();
    tick(2);
    code[2] = 8'hA5;
    p = cyc;
    req = 4'b0100;
    push(8'hA5, 2'd2, p + 21);
    tick(1);
    req = '0;
    wait_idle();

    // all requesters held: round robin from ch0
    do_reset();
    code[0] = 8'h12;
    code[1] = 8'h34;
    code[2] = 8'h56;
    code[3] = 8'h78;
    p = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++)
      push(code[k % 4], 2'(k % 4), p + 21 + 23 * k);
    tick(113);
    req = '0;
    wait_idle();

    // extreme codes and trial sequence
    do_reset();
    code[0] = 8'h00;
    p = cyc;
    req = 4'b0001;
    push(8'h00, 2'd0, p + 21);
    tick(1);
    req = '0;
    wait_idle();

    do_reset();
    code[1] = 8'hFF;
    trials.delete();
    p = cyc;
    req = 4'b0010;
    push(8'hFF, 2'd1, p + 21);
    tick(1);
    req = '0;
    wait_idle();
    chk("trial_count", 32'(trials.size()), 8);
    for (int i = 0; i < 8 && i < trials.size(); i++) begin
      t = 8'hFF;
      t = t << (7 - i);
      chk("trial", 32'(trials[i]), 32'(t));
    end

    // reset in the middle of bit 4
    do_reset();
    code[2] = 8'h3C;
    p = cyc;
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(10);
    chk("bit4_trial", 32'(dac_code), 32'h30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    tick(3);
    code[0] = 8'h5A;
    code[3] = 8'h77;
    p = cyc;
    req = 4'b1001;
    push(8'h5A, 2'd0, p + 21);
    tick(1);
    req = '0;
    wait_idle();

    // enable gating
    do_reset();
    en = 1'b0;
    code[1] = 8'hC3;
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("en_off_busy", 32'(busy), 0);
    end
    p = cyc;
    en = 1'b1;
    push(8'hC3, 2'd1, p + 21);
    tick(1);
    chk("en_on_busy", 32'(busy), 1);
    chk("en_on_ch", 32'(ch_sel), 1);
    tick(7);
    en = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("en_hold_busy", 32'(busy), 0);
    end
    req = '0;
    en = 1'b1;
    tick(2);

    chk("pending", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
